// File: rtl/fp_acc_seq.sv
// FP32 accumulation controller wrapped around an external combinational FP adder.
// Optional sticky Inf/NaN flag on port exc is enabled by defining FP_ACC_EXC_EN.
module fp_acc_seq #(
  parameter int WIDTH = 32,
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_op,
  output logic             in_ready,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_op,
  input  logic [WIDTH-1:0] add_s,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             busy
`ifdef FP_ACC_EXC_EN
  ,
  output logic             exc
`endif
);

  localparam int EXP_W = 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACC,
    S_DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [LEN_W-1:0] cnt;
  logic [WIDTH-1:0] acc;
  logic             first;
  logic             accept;
  logic             start_run;
  logic             last;
  logic [WIDTH-1:0] first_val;

  assign accept    = in_valid && (state == S_ACC);
  assign start_run = start && (state == S_IDLE);
  assign last      = accept && (cnt == LEN_W'(1));

  // The adder cannot take a zero operand, so the first sample bypasses it.
  assign first_val = {in_data[WIDTH-1] ^ in_op, in_data[WIDTH-2:0]};

  assign add_a    = acc;
  assign add_b    = in_data;
  assign add_op   = in_op;
  assign out_data = acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = (len == '0) ? S_DONE : S_ACC;
        end
      end
      S_ACC: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (last) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        if (out_ready) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // cnt only decrements on accept in ACC, where it is at least 1, so it never wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc   <= '0;
      cnt   <= '0;
      first <= 1'b0;
    end else if (start_run) begin
      acc   <= '0;
      cnt   <= len;
      first <= 1'b1;
    end else if (accept) begin
      cnt   <= cnt - LEN_W'(1);
      first <= 1'b0;
      acc   <= first ? first_val : add_s;
    end
  end

`ifdef FP_ACC_EXC_EN
  logic in_special;
  logic sum_special;

  assign in_special  = &in_data[WIDTH-2 -: EXP_W];
  assign sum_special = &add_s[WIDTH-2 -: EXP_W];

  // Adder result only matters when it is actually loaded into acc.
  always_ff @(posedge clk) begin
    if (rst) begin
      exc <= 1'b0;
    end else if (start_run) begin
      exc <= 1'b0;
    end else if (accept && (in_special || (!first && sum_special))) begin
      exc <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fp_acc_seq.sv
// Scoreboard bench for fp_acc_seq with a behavioural FP adder attached to add_a/add_b/add_s.
// Samples are multiples of 0.5 so every running sum is exact in FP32.
module tb_fp_acc_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] len_sig;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_op;
  logic        in_ready;
  logic [31:0] add_a;
  logic [31:0] add_b;
  logic        add_op;
  logic [31:0] add_s;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready;
  logic        busy;
`ifdef FP_ACC_EXC_EN
  logic        exc;
`endif

  typedef struct packed {
    logic [31:0] data;
    logic        exc;
  } exp_t;

  exp_t        expQ[$];
  logic [31:0] stimData[$];
  bit          stimOp[$];
  int          checks = 0;
  int          errors = 0;
  exp_t        ent;

  fp_acc_seq #(.WIDTH(32), .LEN_W(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .len      (len_sig),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_op    (in_op),
    .in_ready (in_ready),
    .add_a    (add_a),
    .add_b    (add_b),
    .add_op   (add_op),
    .add_s    (add_s),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ready(out_ready),
    .busy     (busy)
`ifdef FP_ACC_EXC_EN
    ,
    .exc      (exc)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic real fp2real(logic [31:0] b);
    real m;
    int  e;
    if (b[30:0] == 31'd0) return 0.0;
    m = 1.0 + $itor({9'd0, b[22:0]}) / 8388608.0;
    e = int'({24'd0, b[30:23]}) - 127;
    while (e > 0) begin m = m * 2.0; e--; end
    while (e < 0) begin m = m / 2.0; e++; end
    return b[31] ? -m : m;
  endfunction

  function automatic logic [31:0] real2fp(real x);
    logic        s;
    int          e;
    real         m;
    logic [22:0] f;
    if (x == 0.0) return 32'h0;
    s = (x < 0.0);
    m = s ? -x : x;
    e = 127;
    while (m >= 2.0) begin m = m / 2.0; e++; end
    while (m < 1.0) begin m = m * 2.0; e--; end
    f = 23'($rtoi((m - 1.0) * 8388608.0));
    return {s, 8'(e), f};
  endfunction

  function automatic logic [31:0] adderModel(logic [31:0] a, logic [31:0] b, logic op);
    if ((&a[30:23]) || (&b[30:23])) return 32'h7F800000;
    return real2fp(op ? fp2real(a) - fp2real(b) : fp2real(a) + fp2real(b));
  endfunction

  assign add_s = adderModel(add_a, add_b, add_op);

  // Reference: sign-applied first sample, then plain signed accumulation.
  function automatic logic [31:0] refSum(int n);
    real s = 0.0;
    real v;
    for (int i = 0; i < n; i++) begin
      v = fp2real(stimData[i]);
      if (i == 0) s = stimOp[i] ? -v : v;
      else        s = stimOp[i] ? s - v : s + v;
    end
    return real2fp(s);
  endfunction

  task automatic checkOutput(string name, logic [31:0] act, logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic pushExpect(logic [31:0] d, logic x);
    exp_t e;
    e.data = d;
    e.exc  = x;
    expQ.push_back(e);
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_output: got out_data=%h, expected no output", out_data);
      end else begin
        ent = expQ.pop_front();
        checkOutput(ent.exc ? "sum_special" : "sum", out_data, ent.data);
`ifdef FP_ACC_EXC_EN
        checkOutput("exc", 32'(exc), 32'(ent.exc));
`endif
      end
    end
  end

  task automatic startPulse(int n);
    start   = 1'b1;
    len_sig = 16'(n);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic sendSample(logic [31:0] d, logic op);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_op    = op;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (!in_ready) checkOutput("accept_timeout", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic waitDone(int hold);
    int          n = 0;
    logic [31:0] held;
    while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
    if (!out_valid) checkOutput("done_timeout", 32'(out_valid), 32'd1);
    held = out_data;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      checkOutput("hold_valid", 32'(out_valid), 32'd1);
      checkOutput("hold_data", out_data, held);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput("idle_after_done", 32'(out_valid), 32'd0);
  endtask

  task automatic applyStimulus(int n, int hold, bit randGaps);
    out_ready = 1'b0;
    startPulse(n);
    if (n == 0) checkOutput("zero_len_done", 32'(out_valid), 32'd1);
    for (int i = 0; i < n; i++) begin
      if (randGaps) begin
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
      sendSample(stimData[i], stimOp[i]);
      if (i < n - 1) checkOutput("early_done", 32'(out_valid), 32'd0);
      else           checkOutput("done_latency", 32'(out_valid), 32'd1);
    end
    waitDone(hold);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no completion, expected finish before timeout");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; len_sig = '0; in_valid = 1'b0;
    in_data = '0; in_op = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_out_data", out_data, 32'h0);

    stimData = '{32'h3F800000, 32'h40000000, 32'h3F000000}; stimOp = '{0, 0, 0};
    pushExpect(32'h40600000, 1'b0);
    applyStimulus(3, 0, 0);

    stimData = '{32'h40400000, 32'h3F800000}; stimOp = '{0, 1};
    pushExpect(32'h40000000, 1'b0);
    applyStimulus(2, 1, 0);

    stimData = '{32'h3F800000}; stimOp = '{1};
    pushExpect(32'hBF800000, 1'b0);
    applyStimulus(1, 0, 0);

    stimData.delete(); stimOp.delete();
    pushExpect(32'h00000000, 1'b0);
    applyStimulus(0, 5, 0);

    // Gaps with start asserted mid-run: a honoured start would reload len and delay DONE.
    pushExpect(32'h40600000, 1'b0);
    out_ready = 1'b0;
    startPulse(4);
    sendSample(32'h3F800000, 1'b0);
    for (int i = 0; i < 3; i++) begin
      start = 1'b1; len_sig = 16'd7;
      @(posedge clk); #1;
      checkOutput("gap_busy", 32'(busy), 32'd1);
      checkOutput("gap_in_ready", 32'(in_ready), 32'd1);
    end
    start = 1'b0;
    sendSample(32'h40000000, 1'b1);
    sendSample(32'h40800000, 1'b0);
    sendSample(32'h3F000000, 1'b0);
    checkOutput("gap_done_latency", 32'(out_valid), 32'd1);
    waitDone(1);

    startPulse(4);
    sendSample(32'h40400000, 1'b0);
    sendSample(32'h40400000, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("midrst_in_ready", 32'(in_ready), 32'd0);
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_out_data", out_data, 32'h0);
    repeat (8) begin
      @(posedge clk); #1;
      checkOutput("midrst_no_output", 32'(out_valid), 32'd0);
    end

`ifdef FP_ACC_EXC_EN
    stimData = '{32'h3F800000, 32'h7F800000}; stimOp = '{0, 0};
    pushExpect(32'h7F800000, 1'b1);
    applyStimulus(2, 0, 0);
    stimData = '{32'h3F800000}; stimOp = '{0};
    pushExpect(32'h3F800000, 1'b0);
    applyStimulus(1, 0, 0);
`endif

    for (int r = 0; r < 20; r++) begin
      n = $urandom_range(1, 6);
      stimData.delete(); stimOp.delete();
      for (int i = 0; i < n; i++) begin
        stimData.push_back(real2fp(0.5 * $itor($urandom_range(1, 32))));
        stimOp.push_back(1'($urandom_range(0, 1)));
      end
      pushExpect(refSum(n), 1'b0);
      applyStimulus(n, $urandom_range(0, 3), 1);
    end

    repeat (3) @(posedge clk);
    #1;
    checkOutput("scoreboard_drained", 32'(expQ.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
